// File: rtl/dmi_responder_if.sv
// DMI request/response bus between a DMI initiator (DTM or stimulus) and the
// debug-module responder.
interface dmi_responder_if;
    logic        dmi_rd;
    logic        dmi_wr;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;
    logic        dmi_resp_valid;
    logic        dmi_resp_err;

    modport master (
        output dmi_rd, dmi_wr, dmi_addr, dmi_wdata,
        input  dmi_rdata, dmi_resp_valid, dmi_resp_err
    );

    modport slave (
        input  dmi_rd, dmi_wr, dmi_addr, dmi_wdata,
        output dmi_rdata, dmi_resp_valid, dmi_resp_err
    );
endinterface

// File: rtl/dmi_responder.sv
// Minimal RISC-V Debug Module register set behind a DMI target port, with an
// abstract "access register" command engine driving a req/ack GPR port.
module dmi_responder #(
    parameter int PROGBUF_N   = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    dmi_responder_if.slave dmi,
    input  logic           core_halted,
    output logic           haltreq,
    output logic           ndmreset,
    output logic           gpr_req,
    output logic           gpr_we,
    output logic [4:0]     gpr_addr,
    output logic [31:0]    gpr_wdata,
    input  logic [31:0]    gpr_rdata,
    input  logic           gpr_ack
);

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DATA1      = 7'h05;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    localparam logic [2:0] ERR_BUSY        = 3'd1;
    localparam logic [2:0] ERR_UNSUPPORTED = 3'd2;
    localparam logic [2:0] ERR_EXCEPTION   = 3'd3;
    localparam logic [2:0] ERR_HALT        = 3'd4;

    localparam logic [4:0] PB_N = 5'(PROGBUF_N);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_REQ
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data0_q, data0_d;
    logic [31:0]      data1_q, data1_d;
    logic [31:0]      progbuf_q [PROGBUF_N];
    logic [31:0]      progbuf_d [PROGBUF_N];
    logic             haltreq_q, haltreq_d;
    logic             ndmreset_q, ndmreset_d;
    logic             dmactive_q, dmactive_d;
    logic [2:0]       cmderr_q, cmderr_d;
    logic             gpr_we_q, gpr_we_d;
    logic [4:0]       gpr_addr_q, gpr_addr_d;
    logic [31:0]      gpr_wdata_q, gpr_wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;

    logic        busy;
    logic        pb_hit;
    logic        mapped;
    logic [31:0] rd_mux;
    logic        cmd_start;
    logic        wr_guarded;
    logic [15:0] regno;

    assign busy   = (state_q == ST_REQ);
    assign pb_hit = (dmi.dmi_addr[6:4] == 3'b010) && ({1'b0, dmi.dmi_addr[3:0]} < PB_N);
    assign regno  = dmi.dmi_wdata[15:0];

    // Read view of every register as it stands this cycle.
    always_comb begin
        rd_mux = '0;
        mapped = 1'b1;
        case (dmi.dmi_addr)
            ADDR_DATA0:      rd_mux = data0_q;
            ADDR_DATA1:      rd_mux = data1_q;
            ADDR_DMCONTROL:  rd_mux = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
            ADDR_DMSTATUS:   rd_mux = {22'b0, core_halted, core_halted, 1'b1, 3'b0, 4'd2};
            ADDR_ABSTRACTCS: rd_mux = {3'b0, PB_N, 11'b0, busy, 1'b0, cmderr_q, 4'b0, 4'd2};
            ADDR_COMMAND:    rd_mux = '0;
            default: begin
                mapped = pb_hit;
                for (int i = 0; i < PROGBUF_N; i++) begin
                    if (pb_hit && dmi.dmi_addr[3:0] == 4'(i)) begin
                        rd_mux = progbuf_q[i];
                    end
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        progbuf_d   = progbuf_q;
        haltreq_d   = haltreq_q;
        ndmreset_d  = ndmreset_q;
        dmactive_d  = dmactive_q;
        cmderr_d    = cmderr_q;
        gpr_we_d    = gpr_we_q;
        gpr_addr_d  = gpr_addr_q;
        gpr_wdata_d = gpr_wdata_q;
        cmd_start   = 1'b0;
        wr_guarded  = dmi.dmi_addr == ADDR_DATA0 || dmi.dmi_addr == ADDR_DATA1 ||
                      dmi.dmi_addr == ADDR_COMMAND || pb_hit;

        resp_valid_d = dmi.dmi_rd | dmi.dmi_wr;
        rdata_d      = dmi.dmi_rd ? rd_mux : 32'h0;
        resp_err_d   = (dmi.dmi_rd | dmi.dmi_wr) & ~mapped;

        if (dmi.dmi_wr) begin
            if (busy && wr_guarded) begin
                if (cmderr_q == 3'd0) begin
                    cmderr_d = ERR_BUSY;
                end
            end else begin
                case (dmi.dmi_addr)
                    ADDR_DATA0: data0_d = dmi.dmi_wdata;
                    ADDR_DATA1: data1_d = dmi.dmi_wdata;
                    ADDR_DMCONTROL: begin
                        haltreq_d  = dmi.dmi_wdata[31];
                        ndmreset_d = dmi.dmi_wdata[1];
                        dmactive_d = dmi.dmi_wdata[0];
                    end
                    ADDR_ABSTRACTCS: cmderr_d = cmderr_q & ~dmi.dmi_wdata[10:8];
                    ADDR_COMMAND: begin
                        if (cmderr_q == 3'd0) begin
                            if (dmi.dmi_wdata[31:24] != 8'd0) begin
                                cmderr_d = ERR_UNSUPPORTED;
                            end else if (dmi.dmi_wdata[17]) begin
                                if (regno < 16'h1000 || regno > 16'h101F) begin
                                    cmderr_d = ERR_UNSUPPORTED;
                                end else if (!core_halted) begin
                                    cmderr_d = ERR_HALT;
                                end else begin
                                    cmd_start = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        for (int i = 0; i < PROGBUF_N; i++) begin
                            if (pb_hit && dmi.dmi_addr[3:0] == 4'(i)) begin
                                progbuf_d[i] = dmi.dmi_wdata;
                            end
                        end
                    end
                endcase
            end
        end

        // A timeout lands after the W1C so a same-cycle new error wins over the clear.
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d     = ST_REQ;
                    cnt_d       = '0;
                    gpr_we_d    = dmi.dmi_wdata[16];
                    gpr_addr_d  = regno[4:0];
                    gpr_wdata_d = data0_q;
                end
            end
            ST_REQ: begin
                if (gpr_ack) begin
                    state_d = ST_IDLE;
                    if (!gpr_we_q) begin
                        data0_d = gpr_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    cmderr_d = ERR_EXCEPTION;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (dmi.dmi_wr && dmi.dmi_addr == ADDR_DMCONTROL && !dmi.dmi_wdata[0]) begin
            data0_d    = '0;
            data1_d    = '0;
            cmderr_d   = '0;
            haltreq_d  = 1'b0;
            ndmreset_d = 1'b0;
            for (int i = 0; i < PROGBUF_N; i++) begin
                progbuf_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            dmactive_q   <= 1'b0;
            cmderr_q     <= '0;
            gpr_we_q     <= 1'b0;
            gpr_addr_q   <= '0;
            gpr_wdata_q  <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < PROGBUF_N; i++) begin
                progbuf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            dmactive_q   <= dmactive_d;
            cmderr_q     <= cmderr_d;
            gpr_we_q     <= gpr_we_d;
            gpr_addr_q   <= gpr_addr_d;
            gpr_wdata_q  <= gpr_wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            for (int i = 0; i < PROGBUF_N; i++) begin
                progbuf_q[i] <= progbuf_d[i];
            end
        end
    end

    assign dmi.dmi_rdata      = rdata_q;
    assign dmi.dmi_resp_valid = resp_valid_q;
    assign dmi.dmi_resp_err   = resp_err_q;
    assign haltreq            = haltreq_q;
    assign ndmreset           = ndmreset_q;
    assign gpr_req            = (state_q == ST_REQ);
    assign gpr_we             = gpr_we_q;
    assign gpr_addr           = gpr_addr_q;
    assign gpr_wdata          = gpr_wdata_q;

endmodule

// File: tb/tb_dmi_responder.sv
// Directed bench for dmi_responder: every DMI access queues its expected
// response, which is popped and compared on the following cycle.
module tb_dmi_responder;

    localparam int PROGBUF_N   = 2;
    localparam int ACK_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_halted;
    logic        haltreq;
    logic        ndmreset;
    logic        gpr_req;
    logic        gpr_we;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_wdata;
    logic [31:0] gpr_rdata;
    logic        gpr_ack;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rdata_q [$];
    logic        exp_err_q   [$];
    string       exp_tag_q   [$];

    dmi_responder_if dmi_bus ();

    dmi_responder #(
        .PROGBUF_N   (PROGBUF_N),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dmi         (dmi_bus),
        .core_halted (core_halted),
        .haltreq     (haltreq),
        .ndmreset    (ndmreset),
        .gpr_req     (gpr_req),
        .gpr_we      (gpr_we),
        .gpr_addr    (gpr_addr),
        .gpr_wdata   (gpr_wdata),
        .gpr_rdata   (gpr_rdata),
        .gpr_ack     (gpr_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] abscs(input logic busy, input logic [2:0] cmderr);
        return 32'h0200_0002 | ({31'b0, busy} << 12) | ({29'b0, cmderr} << 8);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pops the response due this cycle and compares it; also catches missing or stray responses.
    task automatic checkOutput();
        string       tag;
        logic [31:0] er;
        logic        ee;
        if (dmi_bus.dmi_resp_valid !== 1'b0 || exp_rdata_q.size() != 0) begin
            checks++;
            assert (dmi_bus.dmi_resp_valid === 1'b1 && exp_rdata_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL resp_valid observed=%b expected_pending=%0d",
                       dmi_bus.dmi_resp_valid, exp_rdata_q.size());
            end
            if (exp_rdata_q.size() != 0) begin
                tag = exp_tag_q.pop_front();
                er  = exp_rdata_q.pop_front();
                ee  = exp_err_q.pop_front();
                if (dmi_bus.dmi_resp_valid === 1'b1) begin
                    checkVal({tag, "_rdata"}, dmi_bus.dmi_rdata, er);
                    checkVal({tag, "_err"}, {31'b0, dmi_bus.dmi_resp_err}, {31'b0, ee});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [6:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        dmi_bus.dmi_rd    = rd;
        dmi_bus.dmi_wr    = wr;
        dmi_bus.dmi_addr  = addr;
        dmi_bus.dmi_wdata = wdata;
        exp_rdata_q.push_back(rd ? exp_rdata : 32'h0);
        exp_err_q.push_back(exp_err);
        exp_tag_q.push_back(tag);
        tick();
        dmi_bus.dmi_rd    = 1'b0;
        dmi_bus.dmi_wr    = 1'b0;
        dmi_bus.dmi_addr  = '0;
        dmi_bus.dmi_wdata = '0;
    endtask

    task automatic rdReg(input string tag, input logic [6:0] addr, input logic [31:0] exp, input logic err);
        applyStimulus(tag, 1'b1, 1'b0, addr, 32'h0, exp, err);
    endtask

    task automatic wrReg(input string tag, input logic [6:0] addr, input logic [31:0] data, input logic err);
        applyStimulus(tag, 1'b0, 1'b1, addr, data, 32'h0, err);
    endtask

    initial begin
        rst_n             = 1'b0;
        core_halted       = 1'b1;
        gpr_rdata         = 32'hBAD0_BAD0;
        gpr_ack           = 1'b0;
        dmi_bus.dmi_rd    = 1'b0;
        dmi_bus.dmi_wr    = 1'b0;
        dmi_bus.dmi_addr  = '0;
        dmi_bus.dmi_wdata = '0;

        repeat (3) @(negedge clk);
        checkVal("rst_resp_valid", {31'b0, dmi_bus.dmi_resp_valid}, 32'h0);
        checkVal("rst_rdata", dmi_bus.dmi_rdata, 32'h0);
        checkVal("rst_gpr_req", {31'b0, gpr_req}, 32'h0);
        checkVal("rst_haltreq", {31'b0, haltreq}, 32'h0);
        checkVal("rst_ndmreset", {31'b0, ndmreset}, 32'h0);
        rst_n = 1'b1;

        // Register map, read-before-write and unmapped decode.
        rdReg("t1_dmstatus", 7'h11, 32'h0000_0382, 1'b0);
        rdReg("t1_abscs", 7'h16, abscs(1'b0, 3'd0), 1'b0);
        wrReg("t2_wr_data0", 7'h04, 32'hDEAD_BEEF, 1'b0);
        rdReg("t2_rd_data0", 7'h04, 32'hDEAD_BEEF, 1'b0);
        wrReg("t2_wr_data1", 7'h05, 32'hA5A5_0000, 1'b0);
        applyStimulus("t2_rdwr_data1", 1'b1, 1'b1, 7'h05, 32'h0000_0001, 32'hA5A5_0000, 1'b0);
        rdReg("t2_rd_data1", 7'h05, 32'h0000_0001, 1'b0);
        wrReg("dmctl_wr", 7'h10, 32'h8000_0003, 1'b0);
        checkVal("dmctl_haltreq", {31'b0, haltreq}, 32'h1);
        checkVal("dmctl_ndmreset", {31'b0, ndmreset}, 32'h1);
        rdReg("dmctl_rd", 7'h10, 32'h8000_0003, 1'b0);
        wrReg("pb0_wr", 7'h20, 32'h1111_1111, 1'b0);
        wrReg("pb1_wr", 7'h21, 32'h2222_2222, 1'b0);
        rdReg("pb0_rd", 7'h20, 32'h1111_1111, 1'b0);
        rdReg("pb1_rd", 7'h21, 32'h2222_2222, 1'b0);
        rdReg("pb2_rd_unmapped", 7'h22, 32'h0, 1'b1);
        wrReg("pb2_wr_unmapped", 7'h22, 32'h3333_3333, 1'b1);
        rdReg("cmd_rd_zero", 7'h17, 32'h0, 1'b0);

        // Deactivating the DM clears its state.
        wrReg("dmactive_clr", 7'h10, 32'h0000_0000, 1'b0);
        checkVal("dmactive_haltreq", {31'b0, haltreq}, 32'h0);
        rdReg("dmactive_data0", 7'h04, 32'h0, 1'b0);
        rdReg("dmactive_data1", 7'h05, 32'h0, 1'b0);
        rdReg("dmactive_pb1", 7'h21, 32'h0, 1'b0);
        wrReg("dmactive_set", 7'h10, 32'h0000_0001, 1'b0);
        rdReg("dmactive_rd", 7'h10, 32'h0000_0001, 1'b0);

        // T3: abstract GPR write, ack in the third request cycle.
        wrReg("t3_data0", 7'h04, 32'hCAFE_F00D, 1'b0);
        wrReg("t3_cmd", 7'h17, 32'h0023_1005, 1'b0);
        checkVal("t3_req_c1", {31'b0, gpr_req}, 32'h1);
        checkVal("t3_we", {31'b0, gpr_we}, 32'h1);
        checkVal("t3_addr", {27'b0, gpr_addr}, 32'd5);
        checkVal("t3_wdata", gpr_wdata, 32'hCAFE_F00D);
        rdReg("t3_abscs_busy", 7'h16, abscs(1'b1, 3'd0), 1'b0);
        checkVal("t3_req_c2", {31'b0, gpr_req}, 32'h1);
        tick();
        checkVal("t3_req_c3", {31'b0, gpr_req}, 32'h1);
        gpr_ack = 1'b1;
        tick();
        gpr_ack = 1'b0;
        checkVal("t3_req_done", {31'b0, gpr_req}, 32'h0);
        rdReg("t3_abscs_idle", 7'h16, abscs(1'b0, 3'd0), 1'b0);
        rdReg("t3_data0_kept", 7'h04, 32'hCAFE_F00D, 1'b0);

        // T4: abstract GPR read, plus a DATA0 write dropped while busy.
        gpr_rdata = 32'h1234_5678;
        wrReg("t4_cmd", 7'h17, 32'h0002_1003, 1'b0);
        checkVal("t4_req", {31'b0, gpr_req}, 32'h1);
        checkVal("t4_we", {31'b0, gpr_we}, 32'h0);
        checkVal("t4_addr", {27'b0, gpr_addr}, 32'd3);
        wrReg("t4_busy_wr", 7'h04, 32'hFFFF_FFFF, 1'b0);
        gpr_ack = 1'b1;
        tick();
        gpr_ack = 1'b0;
        checkVal("t4_req_done", {31'b0, gpr_req}, 32'h0);
        rdReg("t4_data0", 7'h04, 32'h1234_5678, 1'b0);
        rdReg("t4_abscs_err1", 7'h16, abscs(1'b0, 3'd1), 1'b0);
        wrReg("t4_w1c", 7'h16, 32'h0000_0100, 1'b0);
        rdReg("t4_abscs_clr", 7'h16, abscs(1'b0, 3'd0), 1'b0);

        // T5: no ack; a W1C landing on the timeout edge loses to the new error.
        gpr_rdata = 32'h5555_AAAA;
        wrReg("t5_cmd", 7'h17, 32'h0002_1001, 1'b0);
        repeat (ACK_TIMEOUT - 1) tick();
        checkVal("t5_req_last", {31'b0, gpr_req}, 32'h1);
        wrReg("t5_w1c_race", 7'h16, 32'h0000_0700, 1'b0);
        checkVal("t5_req_timeout", {31'b0, gpr_req}, 32'h0);
        rdReg("t5_abscs_err3", 7'h16, abscs(1'b0, 3'd3), 1'b0);
        rdReg("t5_data0_kept", 7'h04, 32'h1234_5678, 1'b0);
        wrReg("t5_cmd_ignored", 7'h17, 32'h0023_1005, 1'b0);
        checkVal("t5_req_ignored", {31'b0, gpr_req}, 32'h0);
        wrReg("t5_w1c", 7'h16, 32'h0000_0700, 1'b0);
        rdReg("t5_abscs_clr", 7'h16, abscs(1'b0, 3'd0), 1'b0);

        // T6: error paths and reset during a request.
        rdReg("t6_unmapped", 7'h7F, 32'h0, 1'b1);
        core_halted = 1'b0;
        rdReg("t6_dmstatus_run", 7'h11, 32'h0000_0082, 1'b0);
        wrReg("t6_cmd_running", 7'h17, 32'h0023_1005, 1'b0);
        checkVal("t6_req_running", {31'b0, gpr_req}, 32'h0);
        rdReg("t6_abscs_err4", 7'h16, abscs(1'b0, 3'd4), 1'b0);
        wrReg("t6_w1c4", 7'h16, 32'h0000_0400, 1'b0);
        core_halted = 1'b1;
        wrReg("t6_cmdtype", 7'h17, 32'h0102_1005, 1'b0);
        rdReg("t6_abscs_cmdtype", 7'h16, abscs(1'b0, 3'd2), 1'b0);
        wrReg("t6_w1c2a", 7'h16, 32'h0000_0200, 1'b0);
        wrReg("t6_regno", 7'h17, 32'h0002_1020, 1'b0);
        checkVal("t6_req_regno", {31'b0, gpr_req}, 32'h0);
        rdReg("t6_abscs_regno", 7'h16, abscs(1'b0, 3'd2), 1'b0);
        wrReg("t6_w1c2b", 7'h16, 32'h0000_0200, 1'b0);
        wrReg("t6_notransfer", 7'h17, 32'h0000_1005, 1'b0);
        checkVal("t6_req_notransfer", {31'b0, gpr_req}, 32'h0);
        rdReg("t6_abscs_noop", 7'h16, abscs(1'b0, 3'd0), 1'b0);

        wrReg("t6_cmd_rst", 7'h17, 32'h0023_1005, 1'b0);
        checkVal("t6_req_before_rst", {31'b0, gpr_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1 checkVal("t6_req_async_rst", {31'b0, gpr_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rdReg("t6_abscs_after_rst", 7'h16, abscs(1'b0, 3'd0), 1'b0);
        rdReg("t6_data0_after_rst", 7'h04, 32'h0, 1'b0);

        tick();
        checkVal("sb_drain", exp_rdata_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
